// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the TX arbiter, its picker and its interface.
package uart_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    localparam int UART_N_REQ      = 4;
    localparam int UART_DATA_W     = 8;
    localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX side of the transmit arbiter.
// master drives requests, slave is the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ  = UART_N_REQ,
    parameter int DATA_W = UART_DATA_W
) ();

    logic                      en;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          req_last;
    logic [N_REQ-1:0]          req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [N_REQ-1:0]          gnt;
    logic                      busy;
    logic                      timeout_evt;

    modport master (
        output en, req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, gnt, busy, timeout_evt
    );

    modport slave (
        input  en, req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, gnt, busy, timeout_evt
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr.
// Purely combinational, wraps modulo N_REQ.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = UART_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         pick,
    output logic [$clog2(N_REQ)-1:0] pick_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_j;

    // Scan upward from ptr, keep the first hit.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        w_j      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[w_j]) begin
                any         = 1'b1;
                pick_idx    = w_j;
                pick[w_j]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX byte channel.
// A grant lasts a whole message, capped by burst and idle limits.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = UART_N_REQ,
    parameter int DATA_W       = UART_DATA_W,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    arb_state_t         r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_ptr;
    logic [BURST_W-1:0] r_burst;
    logic [IDLE_W-1:0]  r_idle;
    logic               r_tevt;

    logic [N_REQ-1:0]   w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any;
    logic [DATA_W-1:0]  w_lane [N_REQ];
    logic               w_busy;
    logic               w_vld;
    logic               w_last;
    logic               w_hs;
    logic               w_burst_done;
    logic               w_idle_done;
    logic               w_rel_hs;
    logic               w_rel_to;
    logic [IDX_W-1:0]   w_next_ptr;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req      (bus.req_valid),
        .ptr      (r_ptr),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign w_lane[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    assign w_busy       = (r_state == ST_GRANT);
    assign w_vld        = w_busy & bus.req_valid[r_gidx];
    assign w_last       = bus.req_last[r_gidx];
    assign w_hs         = w_vld & bus.tx_ready;
    assign w_burst_done = (r_burst == BURST_W'(MAX_BURST - 1));
    assign w_idle_done  = (IDLE_TIMEOUT != 0) &&
                          (r_idle == IDLE_W'(IDLE_TIMEOUT - 1));
    assign w_rel_hs     = w_hs & (w_last | w_burst_done);
    assign w_rel_to     = w_busy & ~w_vld & w_idle_done;
    assign w_next_ptr   = (r_gidx == IDX_W'(N_REQ - 1)) ?
                          '0 : r_gidx + 1'b1;

    // Zero-cycle pass-through from the granted requester.
    assign bus.tx_valid    = w_vld;
    assign bus.tx_data     = w_busy ? w_lane[r_gidx] : '0;
    assign bus.req_ready   = bus.tx_ready ? r_gnt : '0;
    assign bus.gnt         = r_gnt;
    assign bus.busy        = w_busy;
    assign bus.timeout_evt = r_tevt;

    // Grant FSM with burst/idle counters and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_idle  <= '0;
            r_tevt  <= 1'b0;
        end else begin
            r_tevt <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.en && w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_burst <= '0;
                        r_idle  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_rel_hs || w_rel_to) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                    end
                    if (w_hs) begin
                        r_burst <= r_burst + 1'b1;
                        r_idle  <= '0;
                    end else if (!w_vld && IDLE_TIMEOUT != 0) begin
                        r_idle <= r_idle + 1'b1;
                    end
                    r_tevt <= w_rel_to;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
